// File: rtl/i2c_target_regfile_if.sv
// Pad-side and register-file-side signals of i2c_target_regfile, grouped for binding.
`timescale 1ns/1ps
interface i2c_target_regfile_if #(
  parameter int NUM_REGS = 16
);
  localparam int AW = $clog2(NUM_REGS);

  // reg_wr_stb is a one-cycle valid with no ready: the consumer must take
  // reg_wr_addr/reg_wr_data in the cycle the strobe is high.
  logic          scl_i;
  logic          sda_i;
  logic          sda_oe;
  logic          reg_wr_stb;
  logic [AW-1:0] reg_wr_addr;
  logic [7:0]    reg_wr_data;
  logic [AW-1:0] host_raddr;
  logic [7:0]    host_rdata;
  logic          busy;
  logic [2:0]    state_dbg;

  modport slave (
    input  scl_i, sda_i, host_raddr,
    output sda_oe, reg_wr_stb, reg_wr_addr, reg_wr_data, host_rdata, busy, state_dbg
  );

  modport master (
    output scl_i, sda_i, host_raddr,
    input  sda_oe, reg_wr_stb, reg_wr_addr, reg_wr_data, host_rdata, busy, state_dbg
  );
endinterface

// File: rtl/i2c_target_regfile.sv
// I2C target with an auto-incrementing byte register file; open-drain SDA, SCL is never driven.
`timescale 1ns/1ps
module i2c_target_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h51,
  parameter int         NUM_REGS   = 16
) (
  input logic                 CLOCK_50,
  input logic                 RESET_N,
  i2c_target_regfile_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_WAIT_STOP
  } state_e;

  // [0],[1] synchronizer stages; [1] is the synchronized level, [2] its previous value
  logic [2:0]    scl_q, scl_d, sda_q, sda_d;
  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          first_q, first_d;
  logic          phase_q, phase_d;
  logic          rw_q, rw_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [7:0]    regs_q [NUM_REGS];
  logic [7:0]    regs_d [NUM_REGS];
  logic          wr_stb_q, wr_stb_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    host_rdata_q, host_rdata_d;

  logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, load_rd;
  logic [7:0] rx_byte, rd_byte;

  always_comb begin
    scl_d     = {scl_q[1:0], bus.scl_i};
    sda_d     = {sda_q[1:0], bus.sda_i};
    scl_s     = scl_q[1];
    sda_s     = sda_q[1];
    scl_rise  = scl_s & ~scl_q[2];
    scl_fall  = ~scl_s & scl_q[2];
    start_det = scl_s & sda_q[2] & ~sda_s;
    stop_det  = scl_s & ~sda_q[2] & sda_s;
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    sda_oe_d     = sda_oe_q;
    busy_d       = busy_q;
    first_d      = first_q;
    phase_d      = phase_q;
    rw_d         = rw_q;
    ptr_d        = ptr_q;
    regs_d       = regs_q;
    wr_stb_d     = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    host_rdata_d = regs_q[bus.host_raddr];
    load_rd      = 1'b0;
    rx_byte      = {shift_q[6:0], sda_s};
    rd_byte      = regs_q[ptr_q];

    if (stop_det || start_det) begin
      state_d   = stop_det ? S_IDLE : S_ADDR;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 3'd0;
      phase_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ADDR: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (rx_byte[7:1] == SLAVE_ADDR) begin
              state_d = S_ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = rx_byte[0];
              phase_d = 1'b0;
            end else begin
              state_d = S_WAIT_STOP;
            end
          end
        end
        // phase_q=0: the ACK clock is about to start; phase_q=1: the ACK clock has ended
        S_ADDR_ACK, S_WR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = 1'b1;
            phase_d  = 1'b1;
          end else if (state_q == S_ADDR_ACK && rw_q) begin
            load_rd = 1'b1;
          end else begin
            phase_d   = 1'b0;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = S_WR_BYTE;
            if (state_q == S_ADDR_ACK) first_d = 1'b1;
          end
        end
        S_WR_BYTE: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_WR_ACK;
            phase_d = 1'b0;
            if (first_q) begin
              ptr_d   = rx_byte[AW-1:0];
              first_d = 1'b0;
            end else begin
              regs_d[ptr_q] = rx_byte;
              wr_stb_d      = 1'b1;
              wr_addr_d     = ptr_q;
              wr_data_d     = rx_byte;
              ptr_d         = ptr_q + 1'b1;
            end
          end
        end
        S_RD_BYTE: if (scl_fall) begin
          if (bit_cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            state_d  = S_RD_ACK;
            phase_d  = 1'b0;
          end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            sda_oe_d  = ~shift_q[6];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_d = S_WAIT_STOP;
            else       phase_d = 1'b1;
          end else if (scl_fall && phase_q) begin
            load_rd = 1'b1;
          end
        end
        S_WAIT_STOP: sda_oe_d = 1'b0;
        default: state_d = S_IDLE;
      endcase
    end

    // Byte load for a read: MSB goes out immediately, pointer advances at load time
    if (load_rd) begin
      shift_d   = rd_byte;
      sda_oe_d  = ~rd_byte[7];
      ptr_d     = ptr_q + 1'b1;
      bit_cnt_d = 3'd0;
      phase_d   = 1'b0;
      state_d   = S_RD_BYTE;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      scl_q        <= 3'b111;
      sda_q        <= 3'b111;
      state_q      <= S_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      sda_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      first_q      <= 1'b0;
      phase_q      <= 1'b0;
      rw_q         <= 1'b0;
      ptr_q        <= '0;
      wr_stb_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 8'd0;
      host_rdata_q <= 8'd0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'd0;
    end else begin
      scl_q        <= scl_d;
      sda_q        <= sda_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      sda_oe_q     <= sda_oe_d;
      busy_q       <= busy_d;
      first_q      <= first_d;
      phase_q      <= phase_d;
      rw_q         <= rw_d;
      ptr_q        <= ptr_d;
      wr_stb_q     <= wr_stb_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      host_rdata_q <= host_rdata_d;
      regs_q       <= regs_d;
    end
  end

  assign bus.sda_oe      = sda_oe_q;
  assign bus.reg_wr_stb  = wr_stb_q;
  assign bus.reg_wr_addr = wr_addr_q;
  assign bus.reg_wr_data = wr_data_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.busy        = busy_q;
  assign bus.state_dbg   = state_q;
endmodule

// File: doc/i2c_target_regfile.md
Name: i2c_target_regfile

Overview:
- I2C target (slave) responder for the DE2-115 I2C bus; the other end of the on-board Wishbone-driven I2C master.
- Oversamples SCL/SDA on CLOCK_50, detects START/STOP, matches a 7-bit address and ACKs it.
- Implements a byte-addressed register file with an auto-incrementing pointer, supporting both write and read transfers.
- Open-drain SDA only; never drives SCL (no clock stretching).

Parameters:
SLAVE_ADDR, 7'h51, 7-bit bus address answered
NUM_REGS, 16, register file depth in bytes; power of two, 2..256

Ports:
CLOCK_50  input  1  system clock, 50 MHz
RESET_N  input  1  asynchronous active-low reset
scl_i  input  1  SCL pad input, asynchronous
sda_i  input  1  SDA pad input, asynchronous
sda_oe  output  1  1 = pull SDA low; 0 = release SDA (pad is tri-stated)
reg_wr_stb  output  1  one-cycle pulse per data byte written by the master
reg_wr_addr  output  log2(NUM_REGS)  register index of that write
reg_wr_data  output  8  byte written
host_raddr  input  log2(NUM_REGS)  local read port address
host_rdata  output  8  regs[host_raddr], registered, 1-cycle latency
busy  output  1  high from address match until STOP or START

Behaviour:
Reset (RESET_N low):
- sda_oe=0, reg_wr_stb=0, reg_wr_addr=0, reg_wr_data=0, host_rdata=0, busy=0.
- pointer=0, all regs=0, state=IDLE.
- Reset mid-transfer releases SDA immediately.

Input conditioning and event detection:
- scl_i and sda_i each pass through a 2-flop synchronizer, then a third "previous" flop.
- SCL rise = prev 0 / now 1; SCL fall = prev 1 / now 0.
- START = SDA falls while synchronized SCL is high. STOP = SDA rises while synchronized SCL is high.
- START and STOP take priority over any bit event in the same cycle.

Bit handling:
- Receive bits are sampled from synchronized SDA on SCL rise, MSB first.
- All sda_oe changes occur on the cycle after SCL fall is detected (about 3 CLOCK_50 cycles after the pad edge).

State machine:
IDLE:
- Wait for START, then go to ADDR with the bit counter cleared.
- STOP in any state: go to IDLE, sda_oe=0, busy=0.
- START in any state (repeated START): go to ADDR.

ADDR:
- Shift in 8 bits.
- If bits[7:1]==SLAVE_ADDR, go to ADDR_ACK and set busy=1. Otherwise go to WAIT_STOP and do not ACK.

ADDR_ACK:
- On the SCL fall after bit 8, set sda_oe=1 for the 9th clock.
- On the next SCL fall: if R/W=0, release SDA, set first_byte=1, go to WR_BYTE.
- If R/W=1, load shift register from regs[pointer], drive its MSB, go to RD_BYTE.

WR_BYTE:
- Shift 8 bits, then go to WR_ACK and drive ACK exactly as in ADDR_ACK.
- If first_byte: pointer = byte mod NUM_REGS, clear first_byte, no write strobe.
- Otherwise: regs[pointer] = byte; pulse reg_wr_stb once with reg_wr_addr=pointer, reg_wr_data=byte; then pointer = pointer+1, wrapping NUM_REGS-1 to 0.
- The strobe and register write occur on the cycle the 8th bit is sampled.
- After the ACK SCL fall, return to WR_BYTE.

RD_BYTE:
- On each SCL fall, present the next bit: sda_oe = ~bit.
- After the 8th bit's SCL fall, release SDA and go to RD_ACK.
- pointer increments (with wrap) when the byte is loaded.

RD_ACK:
- Sample SDA on SCL rise.
- 0 (ACK): on the following SCL fall, load regs[pointer], drive MSB, go to RD_BYTE.
- 1 (NACK): go to WAIT_STOP with SDA released.

WAIT_STOP:
- sda_oe=0; ignore all bits until STOP or START.

Other rules:
- STOP or START arriving mid-byte discards the partial byte; no strobe, no register write.
- host_rdata reads regs every cycle. A same-cycle bus write to the same index returns the old value; the new value appears the next cycle.

Test Plan:
- START, 0xA2, 0x03, 0xAC, STOP -> ACK on all three bytes; exactly one reg_wr_stb with addr=3, data=0xAC; host_raddr=3 gives host_rdata=0xAC.
- START, 0xA2, 0x0F, 0x11, 0x22, STOP (NUM_REGS=16) -> regs[15]=0x11, regs[0]=0x22 (wrap); two strobes.
- Preload regs[5]=0x5A and regs[6]=0xC3 via writes; START, 0xA2, 0x05, repeated START, 0xA3; master ACKs first byte, NACKs second -> SDA carries 0x5A then 0xC3; SDA released after the NACK; busy drops at STOP.
- START, 0xA4, 0x00, STOP -> no ACK (SDA stays high in the 9th clock); sda_oe never asserts; busy stays 0; no strobes.
- START, 0xA2, 0x02, then STOP after 4 bits of the next byte -> pointer=2; no strobe; regs unchanged; state IDLE.
- RESET_N asserted while sda_oe=1 during an ACK -> sda_oe=0 and busy=0 in the same cycle; regs cleared; next START, 0xA2 is ACKed normally.
